// File: rtl/exe_wb_arbiter_pkg.sv
// Types and constants for the execution-stage writeback arbiter.
//   NFU        number of FU result queues arbitrated
//   EWD        writeback slots per cycle (also per-FU resp/claim width)
//   OPID_VALID bit of exe_bundle_t.opid that marks a valid entry
package exe_wb_arbiter_pkg;

  localparam int unsigned NFU        = 3;
  localparam int unsigned EWD        = 4;
  localparam int unsigned CNT_W      = $clog2(EWD) + 1;
  localparam int unsigned RR_W       = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int unsigned OPID_VALID = 15;

  typedef struct packed {
    logic [15:0] opid;
    logic [4:0]  cause;
    logic        misp;
    logic [31:0] data;
  } exe_bundle_t;

  typedef logic [CNT_W-1:0]         wb_cnt_t;
  typedef logic [RR_W-1:0]          rr_t;
  typedef exe_bundle_t [EWD-1:0]    wb_vec_t;
  typedef wb_vec_t [NFU-1:0]        fu_resp_t;
  typedef logic [NFU-1:0][EWD-1:0]  fu_claim_t;
  typedef wb_cnt_t [NFU-1:0]        fu_cnt_t;

  // Number of leading valid entries; anything after the first hole is ignored.
  function automatic wb_cnt_t lead_valid(wb_vec_t v);
    wb_cnt_t n   = '0;
    logic    run = 1'b1;
    for (int unsigned i = 0; i < EWD; i++) begin
      run = run & v[i].opid[OPID_VALID];
      if (run) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  // True when no valid entry follows an invalid one.
  function automatic logic is_prefix(wb_vec_t v);
    logic gap = 1'b0;
    logic ok  = 1'b1;
    for (int unsigned i = 0; i < EWD; i++) begin
      if (!v[i].opid[OPID_VALID]) gap = 1'b1;
      else if (gap)               ok  = 1'b0;
    end
    return ok;
  endfunction

  // FU visited k-th when the round-robin pointer is rr.
  function automatic int unsigned visit_fu(rr_t rr, int unsigned k);
    int unsigned f = 32'(rr) + k;
    return (f >= NFU) ? f - NFU : f;
  endfunction

  function automatic rr_t next_rr(rr_t rr);
    return (rr == RR_W'(NFU - 1)) ? '0 : rr + RR_W'(1);
  endfunction

endpackage

// File: rtl/exe_wb_arbiter_if.sv
// Bus between the FU result queues, the writeback arbiter and ROB/regfile.
//   flush, wb_ready   control from the pipeline / downstream
//   fu_resp, fu_claim per-FU head entries and the claim prefix returned to each queue
//   wb, wb_cnt        registered writeback bundles and valid-slot count
// master = arbiter side, slave = queue/commit side.
interface exe_wb_arbiter_if;
  import exe_wb_arbiter_pkg::*;

  logic      flush;
  logic      wb_ready;
  fu_resp_t  fu_resp;
  fu_claim_t fu_claim;
  wb_vec_t   wb;
  wb_cnt_t   wb_cnt;

  modport master (input flush, wb_ready, fu_resp, output fu_claim, wb, wb_cnt);
  modport slave  (output flush, wb_ready, fu_resp, input fu_claim, wb, wb_cnt);
endinterface

// File: rtl/exe_wb_arbiter_wb_slot_alloc.sv
// Combinational slot allocator: walks FUs from rr onward, each FU takes
// min(avail, remaining) slots; reports per-FU take, first wb slot and total.
//   avail_i    leading-valid count per FU
//   rr_i       round-robin start FU
//   take_c_o   slots granted per FU
//   base_c_o   first wb slot of each FU's grant
//   total_c_o  slots granted overall
module exe_wb_arbiter_wb_slot_alloc
  import exe_wb_arbiter_pkg::*;
(
  input  fu_cnt_t avail_i,
  input  rr_t     rr_i,
  output fu_cnt_t take_c_o,
  output fu_cnt_t base_c_o,
  output wb_cnt_t total_c_o
);

  // Rotate into visit order with constant indices, allocate, rotate back.
  always_comb begin
    wb_cnt_t rem;
    wb_cnt_t av;
    wb_cnt_t tk;
    take_c_o = '0;
    base_c_o = '0;
    rem      = CNT_W'(EWD);
    av       = '0;
    tk       = '0;
    for (int unsigned k = 0; k < NFU; k++) begin
      av = '0;
      for (int unsigned f = 0; f < NFU; f++) begin
        if (visit_fu(rr_i, k) == f) av = avail_i[f];
      end
      tk = (av < rem) ? av : rem;
      for (int unsigned f = 0; f < NFU; f++) begin
        if (visit_fu(rr_i, k) == f) begin
          take_c_o[f] = tk;
          base_c_o[f] = CNT_W'(EWD) - rem;
        end
      end
      rem = rem - tk;
    end
    total_c_o = CNT_W'(EWD) - rem;
  end

endmodule

// File: rtl/exe_wb_arbiter.sv
// Writeback scheduler: drains NFU result queues into EWD writeback slots,
// round-robin between FUs, one cycle of latency.
//   clk, rst  clock; synchronous active-high reset
//   bus       exe_wb_arbiter_if.master: flush/wb_ready/fu_resp in,
//             fu_claim (combinational), wb/wb_cnt (registered) out
module exe_wb_arbiter
  import exe_wb_arbiter_pkg::*;
(
  input logic              clk,
  input logic              rst,
  exe_wb_arbiter_if.master bus
);

  rr_t     rr_q, rr_d;
  wb_vec_t wb_q, wb_d;
  wb_cnt_t wb_cnt_q, wb_cnt_d;
  fu_cnt_t avail, take, base;
  wb_cnt_t total;
  logic    grant_en;

  // Flush beats wb_ready; reset beats both.
  assign grant_en = !rst && !bus.flush && bus.wb_ready;

  always_comb begin
    avail = '0;
    for (int unsigned f = 0; f < NFU; f++) avail[f] = lead_valid(bus.fu_resp[f]);
  end

  exe_wb_arbiter_wb_slot_alloc u_alloc (
    .avail_i   (avail),
    .rr_i      (rr_q),
    .take_c_o  (take),
    .base_c_o  (base),
    .total_c_o (total)
  );

  // Claims are a prefix of length take[f]; queues pop by that count.
  always_comb begin
    bus.fu_claim = '0;
    if (grant_en) begin
      for (int unsigned f = 0; f < NFU; f++) begin
        for (int unsigned i = 0; i < EWD; i++) begin
          bus.fu_claim[f][i] = (CNT_W'(i) < take[f]);
        end
      end
    end
  end

  // Packing: FU f's entry i lands in slot base[f]+i; unused slots stay all-zero.
  always_comb begin
    wb_d     = '0;
    wb_cnt_d = '0;
    rr_d     = rr_q;
    if (grant_en) begin
      for (int unsigned f = 0; f < NFU; f++) begin
        for (int unsigned i = 0; i < EWD; i++) begin
          for (int unsigned s = 0; s < EWD; s++) begin
            if ((CNT_W'(i) < take[f]) && (base[f] + CNT_W'(i) == CNT_W'(s))) begin
              wb_d[s] = bus.fu_resp[f][i];
            end
          end
        end
      end
      wb_cnt_d = total;
      if (total != '0) rr_d = next_rr(rr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      wb_q     <= '0;
      wb_cnt_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wb_q     <= wb_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  assign bus.wb     = wb_q;
  assign bus.wb_cnt = wb_cnt_q;

  // Queues must present a valid prefix; a hole followed by a valid entry is a queue bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned f = 0; f < NFU; f++) begin
        assert (is_prefix(bus.fu_resp[f]))
          else $warning("fu_resp[%0d] has a valid entry after an invalid one", f);
      end
    end
  end

endmodule
